// File: rtl/fifo_pkg.sv
// Shared helpers for fifo_flags: width arithmetic, flag decoding and
// parameter legality predicates.
package fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } flags_t;

   function automatic int clog2(input int n);
      int r;
      r = 32'sd0;
      for (int v = n - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

   // Count must represent 0..depth inclusive.
   function automatic int cw_of(input int depth);
      return clog2(depth + 32'sd1);
   endfunction

   function automatic bit af_level_ok(input int af, input int depth);
      return (af >= 32'sd1) && (af <= depth);
   endfunction

   function automatic bit ae_level_ok(input int ae, input int depth);
      return (ae >= 32'sd0) && (ae <= depth - 32'sd1);
   endfunction

   function automatic flags_t flags_of(input int cnt, input int depth,
                                       input int af, input int ae);
      flags_t f;
      f.full         = (cnt == depth);
      f.empty        = (cnt == 32'sd0);
      f.almost_full  = (cnt >= af);
      f.almost_empty = (cnt <= ae);
      return f;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for fifo_flags: one synchronous write port, one
// asynchronous read port, no reset on contents.
module fifo_ram #(
   parameter int width  = 4,
   parameter int height = 8,
   parameter int AW     = 3
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [width-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [width-1:0] o_rdata
);

   logic [width-1:0] r_mem [height];

   // Write port: only accepted writes reach here.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_flags.sv
// Single-clock FIFO with fill count, programmable almost flags, optional
// first-word-fall-through, synchronous flush and sticky error flags.
module fifo_flags
   import fifo_pkg::*;
#(
   parameter int width    = 4,
   parameter int height   = 8,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        write,
   input  logic [width-1:0]            data_in,
   input  logic                        read,
   output logic [width-1:0]            data_out,
   output logic                        full,
   output logic                        empty,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic [cw_of(height)-1:0]    count,
   output logic                        overflow,
   output logic                        underflow,
   input  logic                        clear_err
);

   localparam int CW = cw_of(height);
   localparam int PW = clog2(height);
   localparam flags_t RST_FLAGS = flags_of(32'sd0, height, AF_LEVEL, AE_LEVEL);

   if (width < 1 || height < 2) begin : g_bad_geometry
      $error("fifo_flags: width must be >= 1 and height >= 2");
   end
   if (!af_level_ok(AF_LEVEL, height)) begin : g_bad_af
      $error("fifo_flags: AF_LEVEL must lie in 1..height");
   end
   if (!ae_level_ok(AE_LEVEL, height)) begin : g_bad_ae
      $error("fifo_flags: AE_LEVEL must lie in 0..height-1");
   end

   logic [PW-1:0]    r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
   logic [CW-1:0]    r_count, w_count_nxt;
   flags_t           r_flags, w_flags_nxt;
   logic             r_overflow, r_underflow;
   logic [width-1:0] r_dout, w_rd_data;
   logic             w_wr_acc, w_rd_acc, w_ovf_evt, w_uf_evt;

   // Acceptance, error events and next-state pointer/count/flag values.
   always_comb begin
      w_rd_acc  = read & ~r_flags.empty;
      w_wr_acc  = write & (~r_flags.full | w_rd_acc);
      w_ovf_evt = ~flush & write & ~w_wr_acc;
      w_uf_evt  = ~flush & read & r_flags.empty;

      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_count_nxt  = r_count;
      if (flush) begin
         w_wr_ptr_nxt = {PW{1'b0}};
         w_rd_ptr_nxt = {PW{1'b0}};
         w_count_nxt  = {CW{1'b0}};
      end else begin
         // Explicit wrap so non-power-of-2 depths work.
         if (w_wr_acc) begin
            w_wr_ptr_nxt = (r_wr_ptr == PW'(height - 1)) ? {PW{1'b0}} : r_wr_ptr + PW'(1'b1);
         end else begin
            w_wr_ptr_nxt = r_wr_ptr;
         end
         if (w_rd_acc) begin
            w_rd_ptr_nxt = (r_rd_ptr == PW'(height - 1)) ? {PW{1'b0}} : r_rd_ptr + PW'(1'b1);
         end else begin
            w_rd_ptr_nxt = r_rd_ptr;
         end
         if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CW'(1'b1);
         end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - CW'(1'b1);
         end else begin
            w_count_nxt = r_count;
         end
      end
      w_flags_nxt = flags_of(int'(w_count_nxt), height, AF_LEVEL, AE_LEVEL);
   end

   fifo_ram #(
      .width  (width),
      .height (height),
      .AW     (PW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr_acc & ~flush),
      .i_waddr (r_wr_ptr),
      .i_wdata (data_in),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_data)
   );

   // State registers; sticky errors let a new event beat clear_err.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr    <= {PW{1'b0}};
         r_rd_ptr    <= {PW{1'b0}};
         r_count     <= {CW{1'b0}};
         r_flags     <= RST_FLAGS;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_dout      <= {width{1'b0}};
      end else begin
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_count     <= w_count_nxt;
         r_flags     <= w_flags_nxt;
         r_overflow  <= w_ovf_evt | (r_overflow & ~clear_err);
         r_underflow <= w_uf_evt | (r_underflow & ~clear_err);
         if (flush) begin
            r_dout <= {width{1'b0}};
         end else if (w_rd_acc) begin
            r_dout <= w_rd_data;
         end else begin
            r_dout <= r_dout;
         end
      end
   end

   if (FWFT != 0) begin : g_fwft
      assign data_out = r_flags.empty ? {width{1'b0}} : w_rd_data;
   end else begin : g_registered
      assign data_out = r_dout;
   end

   assign full         = r_flags.full;
   assign empty        = r_flags.empty;
   assign almost_full  = r_flags.almost_full;
   assign almost_empty = r_flags.almost_empty;
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags: a registered-read and an FWFT instance
// share stimulus; status and data are checked against hand-derived values.
module tb_fifo_flags;

   logic       clk = 1'b0;
   logic       rst, flush, write, read, clear_err;
   logic [3:0] data_in;

   logic [3:0] d0, d1, cnt0, cnt1;
   logic       full0, empty0, af0, ae0, ovf0, uf0;
   logic       full1, empty1, af1, ae1, ovf1, uf1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fifo_flags #(.width(4), .height(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush), .write(write), .data_in(data_in),
      .read(read), .data_out(d0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(cnt0),
      .overflow(ovf0), .underflow(uf0), .clear_err(clear_err));

   fifo_flags #(.width(4), .height(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush), .write(write), .data_in(data_in),
      .read(read), .data_out(d1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(cnt1),
      .overflow(ovf1), .underflow(uf1), .clear_err(clear_err));

   wire [9:0] st0 = {cnt0, full0, empty0, af0, ae0, ovf0, uf0};
   wire [9:0] st1 = {cnt1, full1, empty1, af1, ae1, ovf1, uf1};

   // Expected status word for depth 8, AF=6, AE=2.
   function automatic logic [9:0] exp_st(input int c, input logic o, input logic u);
      return {4'(c), c == 8, c == 0, c >= 6, c <= 2, o, u};
   endfunction

   task automatic cyc(input logic w, input logic [3:0] d, input logic r,
                      input logic f, input logic ce);
      write = w; data_in = d; read = r; flush = f; clear_err = ce;
      @(posedge clk);
      #1;
      write = 1'b0; read = 1'b0; flush = 1'b0; clear_err = 1'b0; data_in = 4'd0;
   endtask

   task automatic test_reset();
      rst = 1'b0; write = 1'b0; read = 1'b0; flush = 1'b0; clear_err = 1'b0; data_in = 4'd0;
      #12;
      n_chk++;
      if ({st0, st1, d0, d1} !== {exp_st(0, 1'b0, 1'b0), exp_st(0, 1'b0, 1'b0), 8'h00}) begin
         n_fail++;
         $display("FAIL reset_initial got=%h/%h d=%h/%h", st0, st1, d0, d1);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if ({st0, d0} !== {exp_st(0, 1'b0, 1'b1), 4'd6}) begin
         n_fail++;
         $display("FAIL reset_prerun got st=%h d0=%h exp st=%h d0=6", st0, d0, exp_st(0, 1'b0, 1'b1));
      end
      cyc(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      n_chk++;
      if ({st0, st1, d0, d1} !== {exp_st(0, 1'b0, 1'b0), exp_st(0, 1'b0, 1'b0), 8'h00}) begin
         n_fail++;
         $display("FAIL reset_midrun got=%h/%h d=%h/%h", st0, st1, d0, d1);
      end
      #3 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
         n_chk++;
         if ({st0, st1, d1} !== {exp_st(i, 1'b0, 1'b0), exp_st(i, 1'b0, 1'b0), 4'd1}) begin
            n_fail++;
            $display("FAIL fill_%0d got=%h/%h d1=%h exp=%h d1=1", i, st0, st1, d1, exp_st(i, 1'b0, 1'b0));
         end
      end
      cyc(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if ({st0, st1} !== {exp_st(8, 1'b1, 1'b0), exp_st(8, 1'b1, 1'b0)}) begin
         n_fail++;
         $display("FAIL fill_overflow got=%h/%h exp=%h", st0, st1, exp_st(8, 1'b1, 1'b0));
      end
   endtask

   task automatic test_drain();
      for (int k = 1; k <= 8; k++) begin
         n_chk++;
         if (d1 !== 4'(k)) begin
            n_fail++;
            $display("FAIL drain_head_%0d got=%h exp=%h", k, d1, 4'(k));
         end
         cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
         n_chk++;
         if ({st0, st1, d0} !== {exp_st(8 - k, 1'b1, 1'b0), exp_st(8 - k, 1'b1, 1'b0), 4'(k)}) begin
            n_fail++;
            $display("FAIL drain_%0d got=%h/%h d0=%h exp=%h d0=%h", k, st0, st1, d0,
                     exp_st(8 - k, 1'b1, 1'b0), 4'(k));
         end
      end
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if ({st0, st1, d0, d1} !== {exp_st(0, 1'b1, 1'b1), exp_st(0, 1'b1, 1'b1), 4'd8, 4'd0}) begin
         n_fail++;
         $display("FAIL drain_underflow got=%h/%h d=%h/%h exp=%h d=8/0", st0, st1, d0, d1, exp_st(0, 1'b1, 1'b1));
      end
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if ({st0, st1} !== {exp_st(0, 1'b0, 1'b0), exp_st(0, 1'b0, 1'b0)}) begin
         n_fail++;
         $display("FAIL drain_clear got=%h/%h exp=%h", st0, st1, exp_st(0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 1; i <= 8; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if ({st0, st1, d0, d1} !== {exp_st(8, 1'b0, 1'b0), exp_st(8, 1'b0, 1'b0), 4'd1, 4'd2}) begin
         n_fail++;
         $display("FAIL simul_full got=%h/%h d=%h/%h exp=%h d=1/2", st0, st1, d0, d1, exp_st(8, 1'b0, 1'b0));
      end
      for (int k = 2; k <= 9; k++) begin
         cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
         n_chk++;
         if ({cnt0, d0, d1} !== {4'(9 - k), 4'(k), (k == 9) ? 4'd0 : 4'(k + 1)}) begin
            n_fail++;
            $display("FAIL simul_read_%0d got cnt=%0d d=%h/%h exp cnt=%0d d0=%h", k, cnt0, d0, d1, 9 - k, 4'(k));
         end
      end
      cyc(1'b1, 4'd10, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if ({st0, st1, d0, d1} !== {exp_st(1, 1'b0, 1'b1), exp_st(1, 1'b0, 1'b1), 4'd9, 4'd10}) begin
         n_fail++;
         $display("FAIL simul_empty got=%h/%h d=%h/%h exp=%h d=9/a", st0, st1, d0, d1, exp_st(1, 1'b0, 1'b1));
      end
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if ({st0, d0} !== {exp_st(0, 1'b0, 1'b0), 4'd10}) begin
         n_fail++;
         $display("FAIL simul_drain got=%h d0=%h exp=%h d0=a", st0, d0, exp_st(0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_wrap();
      cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         n_chk++;
         if (d1 !== 4'(i)) begin
            n_fail++;
            $display("FAIL wrap_a_head_%0d got=%h exp=%h", i, d1, 4'(i));
         end
         cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
         n_chk++;
         if (d0 !== 4'(i)) begin
            n_fail++;
            $display("FAIL wrap_a_%0d got=%h exp=%h", i, d0, 4'(i));
         end
      end
      for (int i = 6; i <= 11; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (st0 !== exp_st(6, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL wrap_count6 got=%h exp=%h", st0, exp_st(6, 1'b0, 1'b0));
      end
      for (int i = 6; i <= 11; i++) begin
         n_chk++;
         if (d1 !== 4'(i)) begin
            n_fail++;
            $display("FAIL wrap_b_head_%0d got=%h exp=%h", i, d1, 4'(i));
         end
         cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
         n_chk++;
         if (d0 !== 4'(i)) begin
            n_fail++;
            $display("FAIL wrap_b_%0d got=%h exp=%h", i, d0, 4'(i));
         end
      end
      n_chk++;
      if ({st0, st1} !== {exp_st(0, 1'b0, 1'b0), exp_st(0, 1'b0, 1'b0)}) begin
         n_fail++;
         $display("FAIL wrap_end got=%h/%h exp=%h", st0, st1, exp_st(0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_flush_clear();
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if ({st0, st1, d0, d1} !== {exp_st(5, 1'b1, 1'b1), exp_st(5, 1'b1, 1'b1), 4'd3, 4'd4}) begin
         n_fail++;
         $display("FAIL flush_pre got=%h/%h d=%h/%h exp=%h d=3/4", st0, st1, d0, d1, exp_st(5, 1'b1, 1'b1));
      end
      cyc(1'b1, 4'd13, 1'b1, 1'b1, 1'b0);
      n_chk++;
      if ({st0, st1, d0, d1} !== {exp_st(0, 1'b1, 1'b1), exp_st(0, 1'b1, 1'b1), 8'h00}) begin
         n_fail++;
         $display("FAIL flush got=%h/%h d=%h/%h exp=%h d=0/0", st0, st1, d0, d1, exp_st(0, 1'b1, 1'b1));
      end
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if ({st0, st1} !== {exp_st(0, 1'b0, 1'b1), exp_st(0, 1'b0, 1'b1)}) begin
         n_fail++;
         $display("FAIL clear_vs_event got=%h/%h exp=%h", st0, st1, exp_st(0, 1'b0, 1'b1));
      end
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if ({st0, st1} !== {exp_st(0, 1'b0, 1'b0), exp_st(0, 1'b0, 1'b0)}) begin
         n_fail++;
         $display("FAIL clear_err got=%h/%h exp=%h", st0, st1, exp_st(0, 1'b0, 1'b0));
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_simultaneous();
      test_wrap();
      test_flush_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
